// File: rtl/mac_pkg.sv
// Shared token type and signed-arithmetic helpers for the pipelined MAC.
// Helpers work on a wide signed container and take the real width as an argument.
package mac_pkg;

    localparam int MAX_INW = 32;
    localparam int MAXW    = 128;

    // Operand-side values are stored sign-extended to the maximum supported widths.
    typedef struct packed {
        logic                        v;
        logic                        i;
        logic signed [2*MAX_INW-1:0] p;
        logic signed [MAX_INW-1:0]   iv;
    } tok_t;

    typedef struct packed {
        logic signed [MAXW-1:0] sum;
        logic                   ovf;
    } add_t;

    function automatic logic signed [MAXW-1:0] smax(input int w);
        return (MAXW'(1) << (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic signed [MAXW-1:0] smin(input int w);
        return ~smax(w);
    endfunction

    // a and b must already be sign-extended from w bits; the wide sum is then exact.
    function automatic add_t sat_add(input logic signed [MAXW-1:0] a,
                                     input logic signed [MAXW-1:0] b,
                                     input int w,
                                     input logic sat);
        logic signed [MAXW-1:0] s;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        add_t r;
        s     = a + b;
        hi    = smax(w);
        lo    = smin(w);
        r.ovf = (s > hi) || (s < lo);
        if (r.ovf && sat)
            r.sum = s[MAXW-1] ? lo : hi;
        else
            r.sum = (s <<< (MAXW - w)) >>> (MAXW - w);
        return r;
    endfunction

endpackage

// File: rtl/mac_pipe_mult_pipe.sv
// PIPE-deep signed multiplier with init/valid token shift register.
// PIPE=0 passes the freshly formed token straight through.
module mult_pipe
    import mac_pkg::*;
#(
    parameter int INW  = 16,
    parameter int PIPE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [INW-1:0] input0,
    input  logic signed [INW-1:0] input1,
    input  logic signed [INW-1:0] init_value,
    input  logic                  init_acc,
    input  logic                  input_valid,
    output tok_t                  tok,
    output logic                  busy
);

    tok_t in_tok;

    // Init wins over a same-cycle operand pair.
    always_comb begin
        in_tok    = '0;
        in_tok.v  = input_valid & ~init_acc;
        in_tok.i  = init_acc;
        in_tok.p  = (2*MAX_INW)'(input0) * (2*MAX_INW)'(input1);
        in_tok.iv = MAX_INW'(init_value);
    end

    if (PIPE == 0) begin : g_comb
        assign tok  = in_tok;
        assign busy = 1'b0;
    end else begin : g_pipe
        tok_t stage [1:PIPE];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 1; s <= PIPE; s++) stage[s] <= '0;
            end else begin
                stage[1] <= in_tok;
                for (int s = 2; s <= PIPE; s++) stage[s] <= stage[s-1];
            end
        end

        always_comb begin
            busy = 1'b0;
            for (int s = 1; s <= PIPE; s++) busy = busy | stage[s].v | stage[s].i;
        end

        assign tok = stage[PIPE];
    end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate with optional saturation, sticky overflow,
// saturating accumulate counter and pipeline-occupancy status.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int PIPE = 2,
    parameter int SAT  = 0,
    parameter int CNTW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [INW-1:0]  input0,
    input  logic signed [INW-1:0]  input1,
    input  logic signed [INW-1:0]  init_value,
    input  logic                   init_acc,
    input  logic                   input_valid,
    output logic signed [OUTW-1:0] out,
    output logic                   out_valid,
    output logic                   ovf,
    output logic [CNTW-1:0]        acc_cnt,
    output logic                   busy
);

    if (OUTW < 2*INW || PIPE < 0 || PIPE > 4 || INW > MAX_INW || OUTW >= MAXW) begin : g_bad_params
        $error("mac_pipe: illegal parameter combination");
    end

    tok_t tok;
    add_t acc_next;

    mult_pipe #(.INW(INW), .PIPE(PIPE)) u_mult (
        .clk        (clk),
        .reset      (reset),
        .input0     (input0),
        .input1     (input1),
        .init_value (init_value),
        .init_acc   (init_acc),
        .input_valid(input_valid),
        .tok        (tok),
        .busy       (busy)
    );

    assign acc_next = sat_add(MAXW'(out), MAXW'($signed(tok.p)), OUTW, SAT != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            acc_cnt   <= '0;
        end else begin
            out_valid <= tok.v;
            if (tok.i) begin
                out     <= OUTW'($signed(tok.iv));
                acc_cnt <= '0;
                ovf     <= 1'b0;
            end else if (tok.v) begin
                out <= OUTW'(acc_next.sum);
                if (acc_next.ovf) ovf <= 1'b1;
                if (acc_cnt != {CNTW{1'b1}}) acc_cnt <= acc_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: four configurations share one stimulus stream
// and are compared every cycle against a look-back reference model.
module tb_mac_pipe;

    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, init, valid;
    logic signed [15:0] in0, in1, ival;

    logic signed [63:0] out0;
    logic signed [31:0] out1, out2, out3;
    logic ovl0, ovl1, ovl2, ovl3;
    logic ovf0, ovf1, ovf2, ovf3;
    logic bsy0, bsy1, bsy2, bsy3;
    logic [15:0] cnt0, cnt1, cnt3;
    logic [1:0]  cnt2;

    // def: defaults; sat/wrap: 32-bit accumulator; wrap uses a 2-bit counter; p0: PIPE=0
    mac_pipe u_def (.clk(clk), .reset(reset), .input0(in0), .input1(in1), .init_value(ival),
        .init_acc(init), .input_valid(valid), .out(out0), .out_valid(ovl0), .ovf(ovf0),
        .acc_cnt(cnt0), .busy(bsy0));
    mac_pipe #(.OUTW(32), .PIPE(2), .SAT(1), .CNTW(16)) u_sat (.clk(clk), .reset(reset),
        .input0(in0), .input1(in1), .init_value(ival), .init_acc(init), .input_valid(valid),
        .out(out1), .out_valid(ovl1), .ovf(ovf1), .acc_cnt(cnt1), .busy(bsy1));
    mac_pipe #(.OUTW(32), .PIPE(2), .SAT(0), .CNTW(2)) u_wrap (.clk(clk), .reset(reset),
        .input0(in0), .input1(in1), .init_value(ival), .init_acc(init), .input_valid(valid),
        .out(out2), .out_valid(ovl2), .ovf(ovf2), .acc_cnt(cnt2), .busy(bsy2));
    mac_pipe #(.OUTW(32), .PIPE(0), .SAT(1), .CNTW(16)) u_p0 (.clk(clk), .reset(reset),
        .input0(in0), .input1(in1), .init_value(ival), .init_acc(init), .input_valid(valid),
        .out(out3), .out_valid(ovl3), .ovf(ovf3), .acc_cnt(cnt3), .busy(bsy3));

    int    c_pipe [NC] = '{2, 2, 2, 0};
    int    c_outw [NC] = '{64, 32, 32, 32};
    int    c_sat  [NC] = '{0, 1, 0, 1};
    int    c_cntw [NC] = '{16, 16, 2, 16};
    string c_name [NC] = '{"def", "sat", "wrap", "p0"};

    logic signed [127:0] d_out [NC];
    logic d_ovl [NC], d_ovf [NC], d_bsy [NC];
    int   d_cnt [NC];

    assign d_out[0] = 128'(out0);
    assign d_out[1] = 128'(out1);
    assign d_out[2] = 128'(out2);
    assign d_out[3] = 128'(out3);
    assign d_ovl = '{ovl0, ovl1, ovl2, ovl3};
    assign d_ovf = '{ovf0, ovf1, ovf2, ovf3};
    assign d_bsy = '{bsy0, bsy1, bsy2, bsy3};
    assign d_cnt = '{int'(cnt0), int'(cnt1), int'(cnt2), int'(cnt3)};

    typedef struct {
        logic v;
        logic i;
        logic signed [127:0] p;
        logic signed [127:0] iv;
    } mtok_t;

    // Reference: every accepted input token since the last reset; config c acts on the
    // token that entered c_pipe edges ago.
    mtok_t hist [$];
    logic signed [127:0] m_out [NC];
    logic m_ovf [NC], m_ovl [NC];
    int   m_cnt [NC];

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic signed [127:0] wrapw(input logic signed [127:0] s, input int w);
        if (w == 32) return {{96{s[31]}}, s[31:0]};
        return {{64{s[63]}}, s[63:0]};
    endfunction

    function automatic void model_edge(input logic rst, input mtok_t t);
        mtok_t act;
        logic signed [127:0] a, s, lw, mx;
        logic o;
        if (rst) begin
            hist.delete();
            for (int c = 0; c < NC; c++) begin
                m_out[c] = 0; m_ovf[c] = 0; m_ovl[c] = 0; m_cnt[c] = 0;
            end
            return;
        end
        hist.push_back(t);
        if (hist.size() > 8) void'(hist.pop_front());
        for (int c = 0; c < NC; c++) begin
            act = '{1'b0, 1'b0, 128'sd0, 128'sd0};
            if (hist.size() > c_pipe[c]) act = hist[hist.size() - 1 - c_pipe[c]];
            m_ovl[c] = act.v;
            if (act.i) begin
                m_out[c] = act.iv; m_cnt[c] = 0; m_ovf[c] = 0;
            end else if (act.v) begin
                a  = m_out[c];
                s  = a + act.p;
                lw = wrapw(s, c_outw[c]);
                o  = (a[127] == act.p[127]) && (lw[127] != a[127]);
                mx = (128'sd1 <<< (c_outw[c] - 1)) - 128'sd1;
                if (o) m_ovf[c] = 1'b1;
                if (o && c_sat[c] != 0) m_out[c] = a[127] ? -mx - 128'sd1 : mx;
                else m_out[c] = lw;
                if (m_cnt[c] < (1 << c_cntw[c]) - 1) m_cnt[c]++;
            end
        end
    endfunction

    function automatic logic m_busy(input int c);
        int idx;
        m_busy = 1'b0;
        for (int k = 0; k < c_pipe[c]; k++) begin
            idx = hist.size() - 1 - k;
            if (idx >= 0) m_busy = m_busy | hist[idx].v | hist[idx].i;
        end
    endfunction

    function automatic void chk(input string n, input logic signed [127:0] act,
                                input logic signed [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endfunction

    task automatic step(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] v0, input logic it, input logic vl,
                        input logic rs);
        mtok_t t;
        in0 = a; in1 = b; ival = v0; init = it; valid = vl; reset = rs;
        @(posedge clk);
        t.v  = vl & ~it;
        t.i  = it;
        t.p  = 128'(a) * 128'(b);
        t.iv = 128'(v0);
        model_edge(rs, t);
        #1;
        for (int c = 0; c < NC; c++) begin
            chk({c_name[c], ".out"},       d_out[c], m_out[c]);
            chk({c_name[c], ".out_valid"}, 128'(d_ovl[c]), 128'(m_ovl[c]));
            chk({c_name[c], ".ovf"},       128'(d_ovf[c]), 128'(m_ovf[c]));
            chk({c_name[c], ".acc_cnt"},   128'(d_cnt[c]), 128'(m_cnt[c]));
            chk({c_name[c], ".busy"},      128'(d_bsy[c]), 128'(m_busy(c)));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic signed [15:0] a, b, iv;
        logic init, valid;
        longint exp_out;
        logic exp_ovl;
        int exp_cnt;
        logic exp_busy;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed expectations for the default configuration (PIPE=2, OUTW=64).
        vt[0] = '{16'sd0,   16'sd0,   16'sd5,  1'b1, 1'b0, 0,   1'b0, 0, 1'b1};
        vt[1] = '{16'sd3,   16'sd4,   16'sd0,  1'b0, 1'b1, 0,   1'b0, 0, 1'b1};
        vt[2] = '{-16'sd2,  16'sd7,   16'sd0,  1'b0, 1'b1, 5,   1'b0, 0, 1'b1};
        vt[3] = '{16'sd100, -16'sd1,  16'sd0,  1'b0, 1'b1, 17,  1'b1, 1, 1'b1};
        vt[4] = '{16'sd0,   16'sd0,   16'sd0,  1'b0, 1'b0, 3,   1'b1, 2, 1'b1};
        vt[5] = '{16'sd0,   16'sd0,   16'sd0,  1'b0, 1'b0, -97, 1'b1, 3, 1'b0};
        vt[6] = '{16'sd0,   16'sd0,   16'sd0,  1'b0, 1'b0, -97, 1'b0, 3, 1'b0};
        vt[7] = '{16'sd9,   16'sd9,   -16'sd8, 1'b1, 1'b1, -97, 1'b0, 3, 1'b1};
        vt[8] = '{16'sd0,   16'sd0,   16'sd0,  1'b0, 1'b0, -97, 1'b0, 3, 1'b1};
        vt[9] = '{16'sd0,   16'sd0,   16'sd0,  1'b0, 1'b0, -8,  1'b0, 0, 1'b0};

        step(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b1);
        step(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b1);
        chk("reset.out",     128'(out0), 128'sd0);
        chk("reset.ovf",     128'(ovf1), 128'sd0);
        chk("reset.acc_cnt", 128'(cnt0), 128'sd0);
        chk("reset.busy",    128'(bsy0), 128'sd0);

        for (int n = 0; n < 10; n++) begin
            step(vt[n].a, vt[n].b, vt[n].iv, vt[n].init, vt[n].valid, 1'b0);
            chk($sformatf("vec%0d.out", n),       128'(out0), 128'(vt[n].exp_out));
            chk($sformatf("vec%0d.out_valid", n), 128'(ovl0), 128'(vt[n].exp_ovl));
            chk($sformatf("vec%0d.acc_cnt", n),   128'(cnt0), 128'(vt[n].exp_cnt));
            chk($sformatf("vec%0d.busy", n),      128'(bsy0), 128'(vt[n].exp_busy));
        end

        // Overflow: 32767 + 3 * 32767^2 exceeds a 32-bit signed accumulator.
        step(16'sd0, 16'sd0, 16'sh7FFF, 1'b1, 1'b0, 1'b0);
        repeat (3) step(16'sd32767, 16'sd32767, 16'sd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("sat.clamp",    128'(out1), 128'sh7FFFFFFF);
        chk("sat.ovf",      128'(ovf1), 128'sd1);
        chk("wrap.value",   128'(out2), -128'sd1073905662);
        chk("wrap.ovf",     128'(ovf2), 128'sd1);
        chk("def.no_ovf",   128'(out0), 128'sd3221061634);
        step(16'sd1, 16'sd1, 16'sd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("wrap.cnt_sat", 128'(cnt2), 128'sd3);
        chk("def.cnt4",     128'(cnt0), 128'sd4);
        step(16'sd0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("sat.ovf_clear", 128'(ovf1), 128'sd0);

        // PIPE=0: init then a pair on the next cycle, no bubble.
        step(16'sd0, 16'sd0, 16'sd1, 1'b1, 1'b0, 1'b0);
        chk("p0.init", 128'(out3), 128'sd1);
        step(16'sd6, 16'sd7, 16'sd0, 1'b0, 1'b1, 1'b0);
        chk("p0.mac",       128'(out3), 128'sd43);
        chk("p0.out_valid", 128'(ovl3), 128'sd1);
        idle(2);

        // Reset with two tokens in flight.
        step(16'sd0, 16'sd0, 16'sd10, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("mid.pre_out", 128'(out0), 128'sd10);
        step(16'sd5, 16'sd5, 16'sd0, 1'b0, 1'b1, 1'b0);
        step(16'sd6, 16'sd6, 16'sd0, 1'b0, 1'b1, 1'b0);
        chk("mid.busy_in_flight", 128'(bsy0), 128'sd1);
        step(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b1);
        chk("mid.rst_out",  128'(out0), 128'sd0);
        chk("mid.rst_busy", 128'(bsy0), 128'sd0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("mid.after_out",   128'(out0), 128'sd0);
            chk("mid.after_valid", 128'(ovl0), 128'sd0);
            chk("mid.after_cnt",   128'(cnt0), 128'sd0);
        end

        // Random stream biased toward extreme operands to provoke overflow.
        for (int n = 0; n < 400; n++) begin
            logic signed [15:0] ra, rb, ri;
            ra = ($urandom_range(0, 2) == 0) ? 16'sh7FFF : 16'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? -16'sh8000 : 16'($urandom);
            ri = 16'($urandom);
            step(ra, rb, ri, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised successor to the project's single-cycle multiply-accumulate unit.
- Registers the signed multiplier over a configurable number of pipeline stages. Init and valid controls travel through the pipeline alongside the operands.
- Adds optional saturation, a sticky overflow flag, an accumulation counter, and pipeline-occupancy status.
- Sits in the datapath of the matrix-vector engine. The controller streams operand pairs and reads the result once `busy` drops.

Parameters:
- INW, 16: signed operand width.
- OUTW, 64: accumulator width. Must satisfy OUTW >= 2*INW; elaboration fails otherwise.
- PIPE, 2: register stages between operand inputs and the accumulator. Range 0..4; 0 gives single-cycle behaviour.
- SAT, 0: 1 clamps on signed overflow; 0 wraps two's-complement.
- CNTW, 16: width of the accumulation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- input0  in  INW  signed operand A
- input1  in  INW  signed operand B
- init_value  in  INW  signed value loaded into the accumulator on init, sign-extended to OUTW
- init_acc  in  1  load init_value into the accumulator (pipelined, ordered with operands)
- input_valid  in  1  operand pair is valid this cycle
- out  out  OUTW  signed accumulator
- out_valid  out  1  one-cycle pulse: out was updated by an accumulate on the previous edge
- ovf  out  1  sticky signed-overflow flag
- acc_cnt  out  CNTW  number of accumulates since the last init/reset
- busy  out  1  at least one valid or init token is in the pipeline stages

Behaviour:
- Reset: while reset is high at an edge, the following are all cleared to 0:
  - out, out_valid, ovf, acc_cnt;
  - every stage's valid and init bits.
  - busy is 0 the cycle after. Reset mid-stream discards all in-flight tokens.
- Pipeline token:
  - Each cycle, stage 1 captures {v = input_valid & ~init_acc, i = init_acc, p = input0*input1 (2*INW signed), iv = init_value}.
  - Tokens shift one stage per edge unconditionally; there is no stall.
  - The multiply may be retimed across the stages, but the full-precision product must be present at the last stage.
- Latency: a token sampled at edge k acts on the accumulator at edge k+PIPE. With PIPE=0 the act happens at edge k (combinational product).
- Precedence: init_acc and input_valid in the same cycle means init wins and that operand pair is dropped.
- Accumulator stage, with the token at the last stage:
  - i=1: out <= sext(iv); acc_cnt <= 0; ovf <= 0.
  - v=1: sum = out + sext(p), computed at OUTW+1 bits.
    - Signed overflow occurs when the operand signs are equal and the sum's sign differs. On overflow, ovf <= 1.
    - SAT=1: out <= +max (2^(OUTW-1)-1) or -min (-2^(OUTW-1)) according to the overflow direction.
    - SAT=0: out <= low OUTW bits of sum.
    - acc_cnt <= acc_cnt+1, saturating at all-ones (never wraps).
  - Otherwise: out, ovf and acc_cnt hold.
- out_valid: registered; equals 1 exactly the cycle after an accumulate edge. Not asserted for init edges.
- busy: OR of the valid and init bits of all PIPE stages. Always 0 when PIPE=0.
- Back-to-back: one operand pair per cycle is sustained indefinitely. Init followed by an operand pair on the next cycle accumulates onto the fresh init value with no bubble.

Decomposition:
- Package mac_pkg holds:
  - the token struct type (v, i, p, iv);
  - the signed max/min constant functions parameterised on OUTW;
  - the saturating-add function returning {sum, ovf}.
- One sub-module, mult_pipe: the PIPE-deep signed multiplier plus token shift register, with PIPE=0 passthrough. mac_pipe adds the accumulator, flags and counter.

Test Plan:
- Reset then idle (PIPE=2): init_acc=1, init_value=5 at cycle 0 -> out=5 after edge 2, out_valid stays 0, acc_cnt=0, busy high for cycles 1-2.
- Stream 3 pairs starting cycle 1: (3,4), (-2,7), (100,-1) after init 5 -> out = 17, 3, -97 on successive cycles from edge 3; out_valid high 3 cycles; acc_cnt=3.
- Simultaneous init_acc=1, init_value=-8, input_valid=1, operands (9,9) -> out=-8, operands ignored, acc_cnt=0.
- Overflow with SAT=1, OUTW=32, INW=16:
  - init 0x7FFF, then (32767,32767) x3: the first two accumulate exactly; the third would exceed 0x7FFFFFFF, so out=0x7FFFFFFF and ovf=1.
  - A later init clears ovf.
  - With SAT=0 the same stimulus wraps to a negative value and ovf=1.
- Reset asserted while 2 tokens are in flight -> out=0 next cycle, the in-flight tokens never modify out, busy=0.
- PIPE=0 regression: behaviour is cycle-identical to the single-cycle MAC; (6,7) after init 1 gives out=43 after the same edge's next clock.
